// File: rtl/ram_writer_pkg.sv
// Shared types and helpers for the RAM stream writer.
//   wr_state_t  : transfer FSM state (IDLE, RUN, DRAIN, DONE)
//   LATENCY_MAX : deepest supported accept-to-strobe pipeline
//   next_addr() : consecutive address with wrap at numwords-1
package ram_writer_pkg;

  localparam int unsigned LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  // Increment with wrap; depth need not be a power of two.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [31:0] numwords);
    logic [31:0] nxt;
    nxt = (addr >= numwords - 32'd1) ? 32'd0 : addr + 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/ram_write_pipe.sv
// Latency-deep shift register of {valid, address, data} feeding the RAM write
// port. The last stage drives the write strobe, address and data directly.
//   clk, reset (async active-low), clken : clocking; all stages hold when clken=0
//   push, push_addr, push_data           : beat entering stage 0
//   write_en_a, address_a, write_data_a  : last stage, to the RAM port
//   empty                                : no valid bit set in any stage
//   near_empty                           : after the next shift only the last
//                                          stage can hold a valid beat
module ram_write_pipe
  import ram_writer_pkg::*;
#(
  parameter int unsigned width_a   = 32,
  parameter int unsigned widthad_a = 10,
  parameter int unsigned latency   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clken,
  input  logic                 push,
  input  logic [widthad_a-1:0] push_addr,
  input  logic [width_a-1:0]   push_data,
  output logic                 write_en_a,
  output logic [widthad_a-1:0] address_a,
  output logic [width_a-1:0]   write_data_a,
  output logic                 empty,
  output logic                 near_empty
);

  localparam int unsigned DEPTH = (latency < 1) ? 1 :
                                  ((latency > LATENCY_MAX) ? LATENCY_MAX : latency);

  logic [DEPTH-1:0]     vld_q;
  logic [widthad_a-1:0] adr_q [DEPTH];
  logic [width_a-1:0]   dat_q [DEPTH];

  // Shift stages; stage 0 always captures so address/data travel with valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else if (clken) begin
      vld_q[0] <= push;
      adr_q[0] <= push_addr;
      dat_q[0] <= push_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  // Stages 0..DEPTH-3 empty means the final beat reaches the RAM next cycle.
  always_comb begin
    near_empty = 1'b1;
    for (int unsigned i = 0; i + 2 < DEPTH; i++) begin
      if (vld_q[i]) near_empty = 1'b0;
    end
  end

  assign empty        = (vld_q == '0);
  assign write_en_a   = vld_q[DEPTH-1];
  assign address_a    = adr_q[DEPTH-1];
  assign write_data_a = dat_q[DEPTH-1];

endmodule

// File: rtl/ram_stream_writer.sv
// Writes a valid/ready stream into a single-port RAM write port at consecutive
// addresses from a programmed base for a programmed number of words.
//   clk, reset (async active-low), clken : clocking; all state frozen when clken=0
//   start, base_addr, length             : transfer request, honoured in IDLE only
//   in_valid, in_ready, in_data          : input stream
//   write_en_a, address_a, write_data_a  : RAM write port (latency stages after accept)
//   busy                                 : transfer running or draining
//   done                                 : one-cycle pulse after the last write
//   checksum                             : only with RAM_STREAM_WRITER_CHECKSUM_EN;
//                                          modulo-2^width_a sum of written words
module ram_stream_writer
  import ram_writer_pkg::*;
#(
  parameter int unsigned width_a    = 32,
  parameter int unsigned widthad_a  = 10,
  parameter int unsigned numwords_a = 1024,
  parameter int unsigned latency    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clken,
  input  logic                 start,
  input  logic [widthad_a-1:0] base_addr,
  input  logic [widthad_a:0]   length,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width_a-1:0]   in_data,
  output logic                 write_en_a,
  output logic [widthad_a-1:0] address_a,
  output logic [width_a-1:0]   write_data_a,
  output logic                 busy,
  output logic                 done
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
  ,
  output logic [width_a-1:0]   checksum
`endif
);

  localparam int unsigned CW  = widthad_a + 1;
  localparam int unsigned LAT = (latency < 1) ? 1 :
                                ((latency > LATENCY_MAX) ? LATENCY_MAX : latency);

  wr_state_t            state_q, state_d;
  logic [widthad_a-1:0] addr_q, addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 busy_d, done_d;
  logic                 accept, final_beat, start_go;
  logic                 pipe_empty, pipe_near_empty;

  // Ready is gated by clken so no beat is taken while the block is frozen.
  assign in_ready   = ready_q & clken;
  assign accept     = in_valid & in_ready;
  assign final_beat = accept && (cnt_q == CW'(1));
  assign start_go   = (state_q == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state_q <= IDLE;
    else if (clken) state_q <= state_d;
  end

  // Next-state logic. With a single stage the final write is already in the
  // output register, so RUN skips DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (length == '0) ? DONE : RUN;
      RUN:     if (final_beat) state_d = (LAT == 1) ? DONE : DRAIN;
      DRAIN:   if (pipe_near_empty || pipe_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and counter next values. busy/done follow the state one cycle
  // late, so done lands the cycle after the last strobe.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ready_d = (state_d == RUN);
    busy_d  = (state_q == RUN) || (state_q == DRAIN);
    done_d  = (state_q == DONE);
    if (start_go) begin
      addr_d = (32'(base_addr) >= numwords_a) ? '0 : base_addr;
      cnt_d  = length;
    end else if (accept) begin
      addr_d = widthad_a'(next_addr(32'(addr_q), numwords_a));
      cnt_d  = cnt_q - CW'(1);
    end
  end

  // Counters and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (clken) begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  ram_write_pipe #(
    .width_a   (width_a),
    .widthad_a (widthad_a),
    .latency   (LAT)
  ) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .clken        (clken),
    .push         (accept),
    .push_addr    (addr_q),
    .push_data    (in_data),
    .write_en_a   (write_en_a),
    .address_a    (address_a),
    .write_data_a (write_data_a),
    .empty        (pipe_empty),
    .near_empty   (pipe_near_empty)
  );

`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
  // Running sum of words as they reach the RAM; settles by the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (clken) begin
      if (start_go)        checksum <= '0;
      else if (write_en_a) checksum <= checksum + write_data_a;
    end
  end
`endif

endmodule

// File: tb/tb_ram_stream_writer.sv
`timescale 1ns/1ps
module tb_ram_stream_writer;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 10;
  localparam int          NW = 1000;

  logic          clk = 1'b0;
  logic          reset, clken, start, in_valid;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [W-1:0]  in_data;

  logic          a_in_ready, a_we, a_busy, a_done;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_wdata;
  logic          b_in_ready, b_we, b_busy, b_done;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_wdata;
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
  logic [W-1:0]  a_csum, b_csum;
`endif

  ram_stream_writer #(.width_a(W), .widthad_a(AW), .numwords_a(NW), .latency(1)) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .start(start), .base_addr(base_addr),
    .length(length), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .write_en_a(a_we), .address_a(a_addr), .write_data_a(a_wdata), .busy(a_busy),
    .done(a_done)
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
    , .checksum(a_csum)
`endif
  );

  ram_stream_writer #(.width_a(W), .widthad_a(AW), .numwords_a(NW), .latency(3)) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .start(start), .base_addr(base_addr),
    .length(length), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .write_en_a(b_we), .address_a(b_addr), .write_data_a(b_wdata), .busy(b_busy),
    .done(b_done)
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
    , .checksum(b_csum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  typedef struct { int base; int len; bit gappy; int stall_at; int exp_last; } vec_t;

  wr_t  exp_a[$], exp_b[$];
  int   acc_a[$], acc_b[$];
  wr_t  ea, eb;
  int   ta, tb;
  int   ecyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   a_last_wr, a_done_ec, a_done_cnt, a_wr_cnt = 0;
  int   b_last_wr, b_done_ec, b_done_cnt, b_wr_cnt = 0;
  logic [AW-1:0] a_last_addr, b_last_addr;
  bit   a_busy_wr, a_busy_done, a_busy_seen;
  bit   b_busy_wr, b_busy_done, b_busy_seen;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [W-1:0] dword(input int v, input int i);
    return 32'(v) * 32'h0100_0000 + 32'(i) * 32'h0001_0003 + 32'h0000_005A;
  endfunction

  // Enabled-cycle counter: latency is measured in cycles with clken high.
  always @(posedge clk) if (clken) ecyc <= ecyc + 1;

  // Scoreboard monitor for the latency=1 instance.
  always @(negedge clk) begin
    if (reset && clken) begin
      if (in_valid && a_in_ready) acc_a.push_back(ecyc);
      if (a_we) begin
        a_wr_cnt++;
        check("a_wr_expected", 64'(exp_a.size() != 0), 64'd1);
        if (exp_a.size() != 0) begin
          ea = exp_a.pop_front();
          ta = (acc_a.size() != 0) ? acc_a.pop_front() : -100;
          check("a_addr", 64'(a_addr), 64'(ea.addr));
          check("a_data", 64'(a_wdata), 64'(ea.data));
          check("a_latency", 64'(ecyc - ta), 64'd1);
        end
        a_last_wr = ecyc; a_last_addr = a_addr; a_busy_wr = a_busy;
      end
      if (a_done) begin a_done_cnt++; a_done_ec = ecyc; a_busy_done = a_busy; end
      if (a_busy) a_busy_seen = 1'b1;
    end
  end

  // Scoreboard monitor for the latency=3 instance.
  always @(negedge clk) begin
    if (reset && clken) begin
      if (in_valid && b_in_ready) acc_b.push_back(ecyc);
      if (b_we) begin
        b_wr_cnt++;
        check("b_wr_expected", 64'(exp_b.size() != 0), 64'd1);
        if (exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          tb = (acc_b.size() != 0) ? acc_b.pop_front() : -100;
          check("b_addr", 64'(b_addr), 64'(eb.addr));
          check("b_data", 64'(b_wdata), 64'(eb.data));
          check("b_latency", 64'(ecyc - tb), 64'd3);
        end
        b_last_wr = ecyc; b_last_addr = b_addr; b_busy_wr = b_busy;
      end
      if (b_done) begin b_done_cnt++; b_done_ec = ecyc; b_busy_done = b_busy; end
      if (b_busy) b_busy_seen = 1'b1;
    end
  end

  task automatic run_xfer(input int v, input vec_t t);
    int a, k, budget, start_ec;
    bit stalled;
    logic [W-1:0] sum;
    a = (t.base >= NW) ? 0 : t.base;
    sum = '0;
    for (int i = 0; i < t.len; i++) begin
      exp_a.push_back('{AW'(a), dword(v, i)});
      exp_b.push_back('{AW'(a), dword(v, i)});
      sum = sum + dword(v, i);
      a = (a == NW - 1) ? 0 : a + 1;
    end
    a_done_cnt = 0; a_busy_seen = 0; a_last_wr = -1;
    b_done_cnt = 0; b_busy_seen = 0; b_last_wr = -1;
    base_addr = AW'(t.base); length = (AW+1)'(t.len); start = 1'b1; start_ec = ecyc;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; budget = 0; stalled = 0;
    while (k < t.len && budget < 4 * t.len + 40) begin
      if (k == t.stall_at && !stalled) begin
        stalled = 1; clken = 1'b0; in_valid = 1'b1; in_data = dword(v, k);
        repeat (5) begin
          @(negedge clk);
          check("stall_no_ready", 64'({a_in_ready, b_in_ready}), 64'd0);
          @(posedge clk); #1;
        end
        clken = 1'b1; start = 1'b1; base_addr = AW'(500); length = (AW+1)'(2);
      end
      in_valid = t.gappy ? (budget % 2 == 0) : 1'b1;
      in_data  = dword(v, k);
      @(negedge clk);
      if (in_valid && a_in_ready) k++;
      @(posedge clk); #1;
      start = 1'b0; budget++;
    end
    in_valid = 1'b0;
    budget = 0;
    while ((a_done_cnt == 0 || b_done_cnt == 0) && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("a_done_pulses", 64'(a_done_cnt), 64'd1);
    check("b_done_pulses", 64'(b_done_cnt), 64'd1);
    if (t.len == 0) begin
      check("a_done_start_plus2", 64'(a_done_ec - start_ec), 64'd2);
      check("b_done_start_plus2", 64'(b_done_ec - start_ec), 64'd2);
      check("a_busy_never", 64'(a_busy_seen), 64'd0);
      check("b_busy_never", 64'(b_busy_seen), 64'd0);
      check("a_no_writes", 64'(a_last_wr), 64'(-1));
    end else begin
      check("a_done_after_last_wr", 64'(a_done_ec - a_last_wr), 64'd1);
      check("b_done_after_last_wr", 64'(b_done_ec - b_last_wr), 64'd1);
      check("a_busy_at_last_wr", 64'(a_busy_wr), 64'd1);
      check("b_busy_at_last_wr", 64'(b_busy_wr), 64'd1);
      check("a_busy_at_done", 64'(a_busy_done), 64'd0);
      check("b_busy_at_done", 64'(b_busy_done), 64'd0);
      check("a_last_addr", 64'(a_last_addr), 64'(t.exp_last));
      check("b_last_addr", 64'(b_last_addr), 64'(t.exp_last));
    end
    check("a_sb_drained", 64'(exp_a.size()), 64'd0);
    check("b_sb_drained", 64'(exp_b.size()), 64'd0);
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
    check("a_checksum", 64'(a_csum), 64'(sum));
    check("b_checksum", 64'(b_csum), 64'(sum));
`endif
  endtask

  initial begin
    int wa, wb;
    reset = 1'b0; clken = 1'b1; start = 1'b0; in_valid = 1'b0;
    base_addr = '0; length = '0; in_data = '0;
    //            base  len  gap stall last
    vecs[0] = '{   5,    3,  0,  -1,   7};
    vecs[1] = '{ 998,    4,  0,  -1,   1};
    vecs[2] = '{   0,    0,  0,  -1,  -1};
    vecs[3] = '{  10,    4,  1,  -1,  13};
    vecs[4] = '{ 100,    6,  0,   2, 105};
    vecs[5] = '{1010,    2,  0,  -1,   1};
    vecs[6] = '{   0, 1003,  0,  -1,   2};

    #12;
    check("a_reset_outs", 64'({a_we, a_addr, a_wdata, a_busy, a_done, a_in_ready}), 64'd0);
    check("b_reset_outs", 64'({b_we, b_addr, b_wdata, b_busy, b_done, b_in_ready}), 64'd0);
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
    check("a_reset_csum", 64'(a_csum), 64'd0);
    check("b_reset_csum", 64'(b_csum), 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_xfer(i, vecs[i]);

    // Reset with two beats inside the latency=3 pipe.
    base_addr = AW'(20); length = (AW+1)'(8); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_a.push_back('{AW'(20), dword(9, 0)});
    exp_a.push_back('{AW'(21), dword(9, 1)});
    in_valid = 1'b1; in_data = dword(9, 0);
    @(posedge clk); #1;
    in_data = dword(9, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("a_async_reset_outs", 64'({a_we, a_addr, a_wdata, a_busy, a_done, a_in_ready}), 64'd0);
    check("b_async_reset_outs", 64'({b_we, b_addr, b_wdata, b_busy, b_done, b_in_ready}), 64'd0);
`ifdef RAM_STREAM_WRITER_CHECKSUM_EN
    check("a_async_reset_csum", 64'(a_csum), 64'd0);
    check("b_async_reset_csum", 64'(b_csum), 64'd0);
`endif
    check("a_pre_reset_writes", 64'(exp_a.size()), 64'd0);
    acc_a.delete(); acc_b.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; in_valid = 1'b1;
    wa = a_wr_cnt; wb = b_wr_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("a_no_wr_after_reset", 64'(a_wr_cnt - wa), 64'd0);
    check("b_no_wr_after_reset", 64'(b_wr_cnt - wb), 64'd0);
    check("idle_after_reset", 64'({a_busy, b_busy, a_in_ready, b_in_ready}), 64'd0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
